// File: rtl/cory_b2sd.sv
// cory_b2sd: busy-to-start/done converter.
//
// Turns a level busy indication from a peer engine into filtered start/done
// pulses, a filtered busy level, a BUSY watchdog and a completed-job counter.
//
// Parameters
//   FILT  : consecutive equal samples needed to accept a level change (1..255)
//   TOUT  : BUSY timeout in clk cycles, 0 disables it (0..65535)
//   CNT_W : width of the job counter
//
// Ports
//   clk         : clock, all state on rising edge
//   reset_n     : asynchronous active-low reset
//   i_busy      : level busy from the peer engine
//   i_clr       : synchronous clear of o_tout_flag and o_jobs
//   o_start     : one-cycle pulse on an accepted busy rising edge
//   o_done      : one-cycle pulse on an accepted busy falling edge
//   o_busy      : filtered busy level (high in BUSY and HUNG)
//   o_tout      : one-cycle pulse when the BUSY timeout fires
//   o_tout_flag : sticky timeout indication
//   o_jobs      : completed job count, wraps silently
//
// Build option
//   CORY_B2SD_SYNC_EN : when defined, i_busy goes through a 2-flop
//                       synchronizer first (+2 cycles on start and done).
//                       When undefined, i_busy must be synchronous to clk.

module cory_b2sd #(
  parameter int FILT  = 2,
  parameter int TOUT  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_busy,
  input  logic             i_clr,
  output logic             o_start,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_tout,
  output logic             o_tout_flag,
  output logic [CNT_W-1:0] o_jobs
);

  typedef enum logic [1:0] {IDLE, BUSY, HUNG} state_t;

  localparam logic [8:0]  FILT_C   = 9'(FILT);
  localparam logic [15:0] TOUT_C   = 16'(TOUT);
  localparam logic [15:0] TCNT_MAX = '1;

  state_t      state, state_nx;
  logic [7:0]  fcnt, fcnt_nx;
  logic [15:0] tcnt, tcnt_nx, tcnt_inc;
  logic [8:0]  fcnt_inc;
  logic        s, diff, filt_hit, tout_hit;
  logic        start_nx, done_nx, tout_nx;

`ifdef CORY_B2SD_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_busy};
  end

  assign s = sync_q[1];
`else
  assign s = i_busy;
`endif

  assign o_busy = (state != IDLE);

  // Filter counter runs only while the sample disagrees with the filtered
  // level; the change is accepted on the sample that would make it FILT.
  assign diff     = s ^ o_busy;
  assign fcnt_inc = {1'b0, fcnt} + 9'd1;
  assign filt_hit = diff && (fcnt_inc == FILT_C);

  // Saturating so that TOUT=0 never wraps back into a match.
  assign tcnt_inc = (tcnt == TCNT_MAX) ? tcnt : tcnt + 16'd1;
  assign tout_hit = (TOUT_C != 16'd0) && (tcnt_inc == TOUT_C);

  always_comb begin
    state_nx = state;
    fcnt_nx  = (diff && !filt_hit) ? fcnt_inc[7:0] : 8'd0;
    tcnt_nx  = tcnt;
    start_nx = 1'b0;
    done_nx  = 1'b0;
    tout_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (filt_hit) begin
          state_nx = BUSY;
          start_nx = 1'b1;
          tcnt_nx  = 16'd0;
        end
      end
      BUSY: begin
        tcnt_nx = tcnt_inc;
        // A completed job takes precedence over a coincident timeout.
        if (filt_hit) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (tout_hit) begin
          state_nx = HUNG;
          tout_nx  = 1'b1;
        end
      end
      HUNG: begin
        if (filt_hit) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      fcnt    <= 8'd0;
      tcnt    <= 16'd0;
      o_start <= 1'b0;
      o_done  <= 1'b0;
      o_tout  <= 1'b0;
    end else begin
      state   <= state_nx;
      fcnt    <= fcnt_nx;
      tcnt    <= tcnt_nx;
      o_start <= start_nx;
      o_done  <= done_nx;
      o_tout  <= tout_nx;
    end
  end

  // Clear beats a coincident increment or timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_jobs      <= '0;
      o_tout_flag <= 1'b0;
    end else if (i_clr) begin
      o_jobs      <= '0;
      o_tout_flag <= 1'b0;
    end else begin
      if (done_nx) o_jobs      <= o_jobs + CNT_W'(1);
      if (tout_nx) o_tout_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cory_b2sd.sv
// Bench for cory_b2sd. Three instances with different parameter sets share
// clock and reset: a (FILT=2), b (FILT=3), c (FILT=1, TOUT=5, CNT_W=2).
// A sample-history reference model predicts every output each cycle.
module tb_cory_b2sd;

`ifdef CORY_B2SD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic busy_a, busy_b, busy_c, clr_a, clr_b, clr_c;
  logic start_a, done_a, obusy_a, tout_a, flag_a;
  logic start_b, done_b, obusy_b, tout_b, flag_b;
  logic start_c, done_c, obusy_c, tout_c, flag_c;
  logic [7:0] jobs_a, jobs_b;
  logic [1:0] jobs_c;
  logic [4:0] obs_a, obs_b, obs_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cory_b2sd #(.FILT(2), .TOUT(0), .CNT_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .i_busy(busy_a), .i_clr(clr_a),
    .o_start(start_a), .o_done(done_a), .o_busy(obusy_a), .o_tout(tout_a),
    .o_tout_flag(flag_a), .o_jobs(jobs_a));

  cory_b2sd #(.FILT(3), .TOUT(0), .CNT_W(8)) u_b (
    .clk(clk), .reset_n(reset_n), .i_busy(busy_b), .i_clr(clr_b),
    .o_start(start_b), .o_done(done_b), .o_busy(obusy_b), .o_tout(tout_b),
    .o_tout_flag(flag_b), .o_jobs(jobs_b));

  cory_b2sd #(.FILT(1), .TOUT(5), .CNT_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .i_busy(busy_c), .i_clr(clr_c),
    .o_start(start_c), .o_done(done_c), .o_busy(obusy_c), .o_tout(tout_c),
    .o_tout_flag(flag_c), .o_jobs(jobs_c));

  assign obs_a = {start_a, done_a, obusy_a, tout_a, flag_a};
  assign obs_b = {start_b, done_b, obusy_b, tout_b, flag_b};
  assign obs_c = {start_c, done_c, obusy_c, tout_c, flag_c};

  // Reference model: a level change is accepted once the most recent FILT
  // samples all disagree with the current level; the timeout fires when the
  // number of edges since BUSY entry equals TOUT.
  typedef struct {
    int          filt, tout, cntw;
    logic [255:0] hist;
    bit          lvl, hung, start, done, tout_p, flag;
    int          jobs, cyc, entry;
    bit          d0, d1;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mdl_init(int filt, int tout, int cntw);
    mdl_t m;
    m.filt = filt; m.tout = tout; m.cntw = cntw;
    m.hist = '0;
    m.lvl = 0; m.hung = 0; m.start = 0; m.done = 0; m.tout_p = 0; m.flag = 0;
    m.jobs = 0; m.cyc = 0; m.entry = 0; m.d0 = 0; m.d1 = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m_in, bit b, bit clr);
    mdl_t m;
    bit s;
    logic [255:0] mask, win;
    m = m_in;
    m.cyc++;
`ifdef CORY_B2SD_SYNC_EN
    s = m.d1; m.d1 = m.d0; m.d0 = b;
`else
    s = b;
`endif
    m.hist = {m.hist[254:0], s};
    mask = (256'(1) << m.filt) - 256'(1);
    win  = m.hist & mask;
    m.start = 0; m.done = 0; m.tout_p = 0;
    if (!m.lvl && win == mask) begin
      m.lvl = 1; m.hung = 0; m.entry = m.cyc; m.start = 1;
    end else if (m.lvl && win == '0) begin
      m.lvl = 0; m.done = 1; m.jobs = (m.jobs + 1) % (1 << m.cntw);
    end else if (m.lvl && !m.hung && m.tout != 0 && (m.cyc - m.entry) == m.tout) begin
      m.hung = 1; m.tout_p = 1; m.flag = 1;
    end
    if (clr) begin
      m.jobs = 0; m.flag = 0;
    end
    return m;
  endfunction

  function automatic logic [4:0] expv(mdl_t m);
    return {m.start, m.done, m.lvl, m.tout_p, m.flag};
  endfunction

  task automatic models_reset();
    ma = mdl_init(2, 0, 8);
    mb = mdl_init(3, 0, 8);
    mc = mdl_init(1, 5, 2);
  endtask

  // One clock: inputs were set after the previous falling edge; model follows
  // the rising edge, outputs are then observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    ma = mdl_step(ma, busy_a, clr_a);
    mb = mdl_step(mb, busy_b, clr_b);
    mc = mdl_step(mc, busy_c, clr_c);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    busy_a = 1'b1; busy_b = 1'b1; busy_c = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    models_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({obs_a, jobs_a} !== 13'd0) begin
      errors++; $display("FAIL reset_a got %b/%0d exp 0", obs_a, jobs_a);
    end
    checks++;
    if ({obs_b, jobs_b} !== 13'd0) begin
      errors++; $display("FAIL reset_b got %b/%0d exp 0", obs_b, jobs_b);
    end
    checks++;
    if ({obs_c, jobs_c} !== 7'd0) begin
      errors++; $display("FAIL reset_c got %b/%0d exp 0", obs_c, jobs_c);
    end
    busy_a = 1'b0; busy_b = 1'b0; busy_c = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    for (int n = 1; n <= 30; n++) begin
      busy_a = (n <= 20);
      tick();
      checks++;
      if (start_a !== (n == 2 + LAT) || done_a !== (n == 22 + LAT)) begin
        errors++;
        $display("FAIL basic_pulse edge=%0d got start=%b done=%b exp start=%b done=%b",
                 n, start_a, done_a, (n == 2 + LAT), (n == 22 + LAT));
      end
      checks++;
      if (obs_a !== expv(ma) || jobs_a !== 8'(ma.jobs)) begin
        errors++;
        $display("FAIL basic_model edge=%0d got %b/%0d exp %b/%0d", n, obs_a, jobs_a, expv(ma), ma.jobs);
      end
    end
    checks++;
    if (jobs_a !== 8'd1) begin
      errors++; $display("FAIL basic_jobs got %0d exp 1", jobs_a);
    end
  endtask

  task automatic test_glitch();
    // short high glitch, then a real job with a short low glitch inside
    for (int n = 0; n < 32; n++) begin
      busy_b = (n < 2) || (n >= 8 && n < 16) || (n >= 18 && n < 24);
      tick();
      if (n < 8) begin
        checks++;
        if (start_b !== 1'b0 || obusy_b !== 1'b0) begin
          errors++; $display("FAIL glitch_high n=%0d got start=%b busy=%b exp 0 0", n, start_b, obusy_b);
        end
      end
      if (n >= 15 && n < 24) begin
        checks++;
        if (done_b !== 1'b0 || obusy_b !== 1'b1) begin
          errors++; $display("FAIL glitch_low n=%0d got done=%b busy=%b exp 0 1", n, done_b, obusy_b);
        end
      end
      checks++;
      if (obs_b !== expv(mb) || jobs_b !== 8'(mb.jobs)) begin
        errors++;
        $display("FAIL glitch_model n=%0d got %b/%0d exp %b/%0d", n, obs_b, jobs_b, expv(mb), mb.jobs);
      end
    end
  endtask

  task automatic test_timeout();
    for (int n = 1; n <= 26; n++) begin
      busy_c = (n <= 20);
      tick();
      checks++;
      if (tout_c !== (n == 6 + LAT) || obusy_c !== (n >= 1 + LAT && n < 21 + LAT) ||
          done_c !== (n == 21 + LAT)) begin
        errors++;
        $display("FAIL tout_seq edge=%0d got tout=%b busy=%b done=%b", n, tout_c, obusy_c, done_c);
      end
      checks++;
      if (obs_c !== expv(mc) || jobs_c !== 2'(mc.jobs)) begin
        errors++;
        $display("FAIL tout_model edge=%0d got %b/%0d exp %b/%0d", n, obs_c, jobs_c, expv(mc), mc.jobs);
      end
    end
    checks++;
    if (flag_c !== 1'b1 || jobs_c !== 2'd1) begin
      errors++; $display("FAIL tout_final got flag=%b jobs=%0d exp 1 1", flag_c, jobs_c);
    end
  endtask

  task automatic test_wrap();
    clr_c = 1'b1;
    tick();
    clr_c = 1'b0;
    checks++;
    if (jobs_c !== 2'd0 || flag_c !== 1'b0) begin
      errors++; $display("FAIL wrap_clr got jobs=%0d flag=%b exp 0 0", jobs_c, flag_c);
    end
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 7; j++) begin
        busy_c = (j < 3);
        clr_c  = (k == 5) && (j == 3 + LAT);
        tick();
        checks++;
        if (obs_c !== expv(mc) || jobs_c !== 2'(mc.jobs)) begin
          errors++;
          $display("FAIL wrap_model k=%0d j=%0d got %b/%0d exp %b/%0d", k, j, obs_c, jobs_c, expv(mc), mc.jobs);
        end
        if (k == 5 && j == 3 + LAT) begin
          checks++;
          if (done_c !== 1'b1 || jobs_c !== 2'd0) begin
            errors++; $display("FAIL wrap_clr_done got done=%b jobs=%0d exp 1 0", done_c, jobs_c);
          end
        end
      end
      clr_c = 1'b0;
      if (k < 5) begin
        checks++;
        if (jobs_c !== 2'(k % 4)) begin
          errors++; $display("FAIL wrap_count job=%0d got %0d exp %0d", k, jobs_c, k % 4);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    busy_a = 1'b1;
    for (int n = 0; n < 12 && !seen; n++) begin
      tick();
      seen = (obusy_a === 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rmid_enter got busy=%b exp 1 within 12 cycles", obusy_a);
    end
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({obs_a, jobs_a} !== 13'd0) begin
      errors++; $display("FAIL rmid_async got %b/%0d exp 0", obs_a, jobs_a);
    end
    models_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      checks++;
      if (start_a !== (n == 2 + LAT) || done_a !== 1'b0) begin
        errors++;
        $display("FAIL rmid_restart edge=%0d got start=%b done=%b exp start=%b done=0",
                 n, start_a, done_a, (n == 2 + LAT));
      end
    end
    busy_a = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_random();
    int ra, rb, rc;
    ra = 0; rb = 0; rc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (ra == 0) begin busy_a = ~busy_a; ra = $urandom_range(1, 6); end
      if (rb == 0) begin busy_b = ~busy_b; rb = $urandom_range(1, 7); end
      if (rc == 0) begin busy_c = ~busy_c; rc = $urandom_range(1, 12); end
      ra--; rb--; rc--;
      clr_a = ($urandom_range(0, 15) == 0);
      clr_b = ($urandom_range(0, 15) == 0);
      clr_c = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (obs_a !== expv(ma) || jobs_a !== 8'(ma.jobs)) begin
        errors++; $display("FAIL rand_a i=%0d got %b/%0d exp %b/%0d", i, obs_a, jobs_a, expv(ma), ma.jobs);
      end
      checks++;
      if (obs_b !== expv(mb) || jobs_b !== 8'(mb.jobs)) begin
        errors++; $display("FAIL rand_b i=%0d got %b/%0d exp %b/%0d", i, obs_b, jobs_b, expv(mb), mb.jobs);
      end
      checks++;
      if (obs_c !== expv(mc) || jobs_c !== 2'(mc.jobs)) begin
        errors++; $display("FAIL rand_c i=%0d got %b/%0d exp %b/%0d", i, obs_c, jobs_c, expv(mc), mc.jobs);
      end
    end
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cory_b2sd.md
CORY_B2SD -- requirements
Module: cory_b2sd

Interface
REQ-001 Parameter FILT, default 2: consecutive equal samples of busy needed to accept a level change; legal range 1..255.
REQ-002 Parameter TOUT, default 0: BUSY timeout in clk cycles; 0 disables timeout; legal range 0..65535.
REQ-003 Parameter CNT_W, default 8: width of the job counter.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_busy  input  1  level busy indication from a peer engine.
REQ-007 i_clr  input  1  synchronous clear of o_tout_flag and o_jobs.
REQ-008 o_start  output  1  one-cycle pulse: accepted busy rising edge.
REQ-009 o_done  output  1  one-cycle pulse: accepted busy falling edge.
REQ-010 o_busy  output  1  filtered busy level, high in BUSY and HUNG.
REQ-011 o_tout  output  1  one-cycle pulse when the timeout fires.
REQ-012 o_tout_flag  output  1  sticky timeout indication.
REQ-013 o_jobs  output  CNT_W  count of completed jobs (o_done pulses).

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, HUNG; o_busy high exactly when the state is not IDLE.
REQ-015 s denotes sampled busy: i_busy directly, or the synchronizer output when CORY_B2SD_SYNC_EN is defined.
REQ-016 The filter counter SHALL increment on each edge where s differs from o_busy and clear to 0 on each edge where s equals o_busy.
REQ-017 IDLE->BUSY on the edge where the counter would reach FILT; o_start SHALL be high for exactly the following cycle; counter cleared.
REQ-018 With FILT=1, i_busy high before edge k SHALL give o_start high after edge k (no sync); each extra FILT adds one cycle.
REQ-019 BUSY->IDLE on the edge where the low count would reach FILT; o_done SHALL be high for exactly the following cycle; o_jobs increments on that edge.
REQ-020 Pulses shorter than FILT samples in either direction SHALL be ignored: no state change, no pulse.
REQ-021 A timeout counter SHALL clear on entry to BUSY and increment each cycle in BUSY; when TOUT!=0 and it reaches TOUT, the FSM goes BUSY->HUNG, o_tout pulses for one cycle, and o_tout_flag sets.
REQ-022 HUNG->IDLE on the same filtered low condition as BUSY; o_done SHALL pulse and o_jobs SHALL increment.
REQ-023 o_start and o_done SHALL never be high in the same cycle, and each SHALL be followed by at least FILT cycles before the opposite pulse.
REQ-024 o_jobs SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-025 i_clr SHALL clear o_jobs and o_tout_flag on the next edge; if an o_done increment or timeout coincides with i_clr, i_clr wins (result 0).
REQ-026 i_clr SHALL NOT affect FSM state, filter counter, or timeout counter.
REQ-027 With TOUT=0, the timeout counter SHALL saturate rather than wrap, and HUNG is unreachable.

Reset
REQ-028 Assertion of reset_n low SHALL immediately force IDLE, all counters 0, o_start=0, o_done=0, o_busy=0, o_tout=0, o_tout_flag=0, o_jobs=0, and synchronizer flops 0.
REQ-029 Reset mid-BUSY SHALL produce no o_done; after release, a still-high i_busy SHALL be treated as a new rising edge (o_start after FILT samples).

Configuration
REQ-030 Macro CORY_B2SD_SYNC_EN: when defined, i_busy passes through a 2-flop synchronizer before the filter, adding exactly 2 cycles latency to o_start and o_done.
REQ-031 When CORY_B2SD_SYNC_EN is undefined, i_busy feeds the filter directly, and i_busy SHALL be synchronous to clk.

Verification
REQ-032 FILT=2, no sync: i_busy high at edge 10, held 20 cycles -> o_start high cycle after edge 11; o_done high cycle after edge 31; o_jobs=1.
REQ-033 FILT=3: i_busy 2-cycle high glitch -> no o_start, o_busy stays 0; 2-cycle low glitch mid-BUSY -> no o_done.
REQ-034 TOUT=5, FILT=1: busy held 20 cycles -> o_tout pulse 5 cycles after o_start, o_tout_flag=1, o_busy stays 1, o_done on the falling edge, o_jobs=1.
REQ-035 CNT_W=2: 4 complete jobs -> o_jobs 1,2,3,0; i_clr coincident with the 5th o_done -> o_jobs=0.
REQ-036 reset_n low during BUSY with i_busy held high -> outputs 0 immediately, no o_done; after release, o_start after FILT cycles.
REQ-037 CORY_B2SD_SYNC_EN defined, FILT=2: o_start and o_done each 2 cycles later than in REQ-032.
